// File: rtl/ecc_word_packer.sv
// ecc_word_packer
//   Gathers 16-bit ingress words into 8-word (128-bit) groups for the ECC
//   encoder / SRAM write stage. One group of double buffering (fill buffer
//   plus output register) keeps ingress flowing while downstream stalls.
//
// Ports:
//   clk, rst          single clock, synchronous active-high reset
//   in_valid/in_ready ingress handshake; in_data word, in_last ends packet
//   out_valid/out_ready egress handshake
//   out_data          word k at [16k+15:16k], word 0 received first
//   out_cnt           valid words in group (1..8)
//   out_last          group ends a packet
//   out_grp           group index within the packet (wraps silently)
//
// Configuration:
//   ECC_PACK_ZERO_PAD_EN  when defined, unused slots of a completed group
//                         are forced to zero; otherwise they hold stale data.
module ecc_word_packer #(
  parameter int GRP_IDX_W = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [15:0]          in_data,
  input  logic                 in_last,
  output logic                 in_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [127:0]         out_data,
  output logic [3:0]           out_cnt,
  output logic                 out_last,
  output logic [GRP_IDX_W-1:0] out_grp
);

  logic [127:0]         fill_q, fill_d;
  logic [127:0]         wr_data, grp_data;
  logic [2:0]           wp_q, wp_d;
  logic                 fill_full_q, fill_full_d;
  logic [3:0]           pend_cnt_q, pend_cnt_d;
  logic                 pend_last_q, pend_last_d;
  logic [GRP_IDX_W-1:0] pend_grp_q, pend_grp_d;
  logic [GRP_IDX_W-1:0] gi_q, gi_d;
  logic                 out_valid_q, out_valid_d;
  logic [127:0]         out_data_q, out_data_d;
  logic [3:0]           out_cnt_q, out_cnt_d;
  logic                 out_last_q, out_last_d;
  logic [GRP_IDX_W-1:0] out_grp_q, out_grp_d;

  logic                 acc;
  logic                 complete;
  logic                 out_free;
  logic [3:0]           grp_cnt;

  always_comb begin
    in_ready = !fill_full_q && !rst;
    acc      = in_valid && in_ready;
    complete = acc && ((wp_q == 3'd7) || in_last);
    // Output register can take a new group if empty or draining this edge.
    out_free = !out_valid_q || out_ready;
    grp_cnt  = {1'b0, wp_q} + 4'd1;

    wr_data = fill_q;
    wr_data[{wp_q, 4'b0000} +: 16] = in_data;

    grp_data = wr_data;
`ifdef ECC_PACK_ZERO_PAD_EN
    for (int k = 0; k < 8; k++) begin
      if (k > int'(wp_q)) grp_data[k*16 +: 16] = 16'h0000;
    end
`endif

    fill_d      = fill_q;
    wp_d        = wp_q;
    fill_full_d = fill_full_q;
    pend_cnt_d  = pend_cnt_q;
    pend_last_d = pend_last_q;
    pend_grp_d  = pend_grp_q;
    gi_d        = gi_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_cnt_d   = out_cnt_q;
    out_last_d  = out_last_q;
    out_grp_d   = out_grp_q;

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    if (acc) begin
      fill_d = complete ? grp_data : wr_data;
      wp_d   = complete ? 3'd0 : wp_q + 3'd1;
      if (complete) begin
        gi_d = in_last ? '0 : gi_q + 1'b1;
        if (out_free) begin
          out_valid_d = 1'b1;
          out_data_d  = grp_data;
          out_cnt_d   = grp_cnt;
          out_last_d  = in_last;
          out_grp_d   = gi_q;
        end else begin
          // Park the group; ingress stalls until the output register drains.
          fill_full_d = 1'b1;
          pend_cnt_d  = grp_cnt;
          pend_last_d = in_last;
          pend_grp_d  = gi_q;
        end
      end
    end

    // A parked group implies out_valid_q, so out_ready alone means a drain.
    if (fill_full_q && out_ready) begin
      out_valid_d = 1'b1;
      out_data_d  = fill_q;
      out_cnt_d   = pend_cnt_q;
      out_last_d  = pend_last_q;
      out_grp_d   = pend_grp_q;
      fill_full_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q        <= 3'd0;
      fill_full_q <= 1'b0;
      pend_cnt_q  <= 4'd0;
      pend_last_q <= 1'b0;
      pend_grp_q  <= '0;
      gi_q        <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_cnt_q   <= 4'd0;
      out_last_q  <= 1'b0;
      out_grp_q   <= '0;
    end else begin
      wp_q        <= wp_d;
      fill_full_q <= fill_full_d;
      pend_cnt_q  <= pend_cnt_d;
      pend_last_q <= pend_last_d;
      pend_grp_q  <= pend_grp_d;
      gi_q        <= gi_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_cnt_q   <= out_cnt_d;
      out_last_q  <= out_last_d;
      out_grp_q   <= out_grp_d;
    end
  end

  // Buffer contents need no reset: wp/fill_full decide what is meaningful.
  always_ff @(posedge clk) begin
    fill_q <= fill_d;
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_cnt   = out_cnt_q;
  assign out_last  = out_last_q;
  assign out_grp   = out_grp_q;

endmodule

// File: tb/tb_ecc_word_packer.sv
module tb_ecc_word_packer;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [15:0]  in_data;
  logic         in_last;
  logic         in_ready;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic [3:0]   out_cnt;
  logic         out_last;
  logic [5:0]   out_grp;

  ecc_word_packer #(.GRP_IDX_W(6)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_cnt(out_cnt), .out_last(out_last), .out_grp(out_grp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] data;
    logic [127:0] mask;
    logic [3:0]   cnt;
    logic         last;
    logic [5:0]   grp;
  } grp_t;

  typedef struct {
    int          len;
    logic [15:0] base;
    bit          rnd;
    int          exp_groups;
    logic [3:0]  exp_last_cnt;
  } vec_t;

  grp_t sb[$];
  vec_t vt[6];

  int n_checks = 0;
  int n_fail   = 0;
  int n_pops   = 0;

  logic [15:0]  mw[8];
  int           mcnt = 0;
  int           mgi  = 0;
  bit           rnd_mode = 1'b0;

  logic [127:0] last_data;
  logic [3:0]   last_cnt;
  logic         last_last;
  logic [5:0]   last_grp;

  bit           stall_prev = 1'b0;
  logic [139:0] stall_snap;

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: collect accepted words, emit an expected group on completion.
  task automatic model_accept(input logic [15:0] d, input logic l);
    grp_t g;
    mw[mcnt] = d;
    mcnt++;
    if (mcnt == 8 || l) begin
      g.data = '0;
      g.mask = '0;
      for (int k = 0; k < 8; k++) begin
        if (k < mcnt) begin
          g.data[k*16 +: 16] = mw[k];
          g.mask[k*16 +: 16] = 16'hFFFF;
        end
      end
`ifdef ECC_PACK_ZERO_PAD_EN
      g.mask = {128{1'b1}};
`endif
      g.cnt  = 4'(mcnt);
      g.last = l;
      g.grp  = 6'(mgi);
      sb.push_back(g);
      mgi  = l ? 0 : (mgi + 1) % 64;
      mcnt = 0;
    end
  endtask

  task automatic send(input logic [15:0] d, input logic l);
    bit r;
    int t;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    t = 0;
    forever begin
      @(negedge clk);
      r = in_ready;
      @(posedge clk);
      if (r) break;
      t++;
      if (t > 200) break;
    end
    if (t > 200) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: word %h never accepted, required acceptance", d);
    end else begin
      model_accept(d, l);
    end
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    rnd_mode = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    t = 0;
    while (sb.size() != 0 && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("drain_empty", 160'(sb.size()), 160'd0);
  endtask

  always @(posedge clk) begin
    if (rnd_mode) begin
      #1;
      out_ready = 1'($urandom_range(0, 1));
    end
  end

  // Output monitor: stability while stalled, scoreboard compare on transfer.
  always @(negedge clk) begin
    grp_t e;
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev)
        chk("hold_stable", 160'({out_valid, out_data, out_cnt, out_last, out_grp}), 160'(stall_snap));
      if (out_valid && out_ready) begin
        n_pops++;
        last_data = out_data;
        last_cnt  = out_cnt;
        last_last = out_last;
        last_grp  = out_grp;
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_group: got grp %0d cnt %0d, required no group", out_grp, out_cnt);
        end else begin
          e = sb.pop_front();
          chk("grp_data", 160'(out_data & e.mask), 160'(e.data & e.mask));
          chk("grp_cnt",  160'(out_cnt),  160'(e.cnt));
          chk("grp_last", 160'(out_last), 160'(e.last));
          chk("grp_idx",  160'(out_grp),  160'(e.grp));
        end
      end
      stall_prev = out_valid && !out_ready;
      stall_snap = {out_valid, out_data, out_cnt, out_last, out_grp};
    end
  end

  initial begin
    int p0;
    vt[0] = '{len: 1,  base: 16'h1234, rnd: 1'b0, exp_groups: 1, exp_last_cnt: 4'd1};
    vt[1] = '{len: 9,  base: 16'h0100, rnd: 1'b1, exp_groups: 2, exp_last_cnt: 4'd1};
    vt[2] = '{len: 17, base: 16'h2000, rnd: 1'b1, exp_groups: 3, exp_last_cnt: 4'd1};
    vt[3] = '{len: 8,  base: 16'h3000, rnd: 1'b0, exp_groups: 1, exp_last_cnt: 4'd8};
    vt[4] = '{len: 13, base: 16'h4000, rnd: 1'b1, exp_groups: 2, exp_last_cnt: 4'd5};
    vt[5] = '{len: 24, base: 16'h5000, rnd: 1'b1, exp_groups: 3, exp_last_cnt: 4'd8};

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready",  160'(in_ready),  160'd0);
    chk("rst_out_valid", 160'(out_valid), 160'd0);
    chk("rst_out_data",  160'(out_data),  160'd0);
    chk("rst_out_meta",  160'({out_cnt, out_last, out_grp}), 160'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", 160'(in_ready), 160'd1);

    // 16-word packet, out_ready high: two full groups, latency of one cycle.
    p0 = n_pops;
    for (int i = 1; i <= 16; i++) begin
      send(16'(i), i == 16);
      if (i == 8 || i == 16) chk("lat_out_valid", 160'(out_valid), 160'd1);
    end
    wait_drain();
    chk("p16_groups", 160'(n_pops - p0), 160'd2);
    chk("p16_last",   160'({last_cnt, last_last, last_grp}), 160'({4'd8, 1'b1, 6'd1}));

    // 3-word packet.
    send(16'hAAAA, 1'b0);
    send(16'hBBBB, 1'b0);
    send(16'hCCCC, 1'b1);
    wait_drain();
    chk("p3_meta", 160'({last_cnt, last_last, last_grp}), 160'({4'd3, 1'b1, 6'd0}));
`ifdef ECC_PACK_ZERO_PAD_EN
    chk("p3_pad", 160'(last_data[127:48]), 160'd0);
`endif

    // Table-driven packets, some under random backpressure.
    for (int i = 0; i < 6; i++) begin
      p0 = n_pops;
      rnd_mode = vt[i].rnd;
      for (int j = 0; j < vt[i].len; j++)
        send(vt[i].base + 16'(j), j == vt[i].len - 1);
      wait_drain();
      chk("tbl_groups",   160'(n_pops - p0), 160'(vt[i].exp_groups));
      chk("tbl_last_cnt", 160'(last_cnt), 160'(vt[i].exp_last_cnt));
      chk("tbl_last",     160'(last_last), 160'd1);
    end

    // Stall: 16 words with out_ready low fill both buffers.
    p0 = n_pops;
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) send(16'h6000 + 16'(i), 1'b0);
    chk("stall_in_ready", 160'(in_ready), 160'd0);
    chk("stall_head",     160'({out_valid, out_grp}), 160'({1'b1, 6'd0}));
    repeat (3) @(posedge clk);
    #1;
    chk("stall_in_ready_hold", 160'(in_ready), 160'd0);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("stall_release_in_ready", 160'(in_ready), 160'd1);
    chk("stall_release_head",     160'({out_valid, out_grp}), 160'({1'b1, 6'd1}));
    for (int i = 16; i < 24; i++) send(16'h6000 + 16'(i), i == 23);
    wait_drain();
    chk("stall_groups", 160'(n_pops - p0), 160'd3);

    // Completion on the same edge the previous group drains.
    p0 = n_pops;
    out_ready = 1'b0;
    for (int i = 0; i < 15; i++) send(16'h7000 + 16'(i), 1'b0);
    out_ready = 1'b1;
    send(16'h700F, 1'b1);
    chk("same_edge_out", 160'({out_valid, out_cnt, out_grp}), 160'({1'b1, 4'd8, 6'd1}));
    chk("same_edge_in_ready", 160'(in_ready), 160'd1);
    wait_drain();
    chk("same_edge_groups", 160'(n_pops - p0), 160'd2);

    // 520-word packet: index wraps 63 -> 0 on the 65th group.
    p0 = n_pops;
    for (int i = 0; i < 520; i++) send(16'(i * 3 + 1), i == 519);
    wait_drain();
    chk("wrap_groups", 160'(n_pops - p0), 160'd65);
    chk("wrap_last",   160'({last_cnt, last_last, last_grp}), 160'({4'd8, 1'b1, 6'd0}));

    // Reset mid-group discards buffered words.
    for (int i = 0; i < 5; i++) send(16'hDEAD + 16'(i), 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_in_ready", 160'(in_ready), 160'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    mcnt = 0;
    mgi  = 0;
    chk("mid_rst_out_valid", 160'(out_valid), 160'd0);
    p0 = n_pops;
    send(16'h0A0A, 1'b0);
    send(16'h0B0B, 1'b1);
    wait_drain();
    chk("mid_rst_groups", 160'(n_pops - p0), 160'd1);
    chk("mid_rst_meta",   160'({last_cnt, last_last, last_grp}), 160'({4'd2, 1'b1, 6'd0}));
    chk("mid_rst_words",  160'(last_data[31:0]), 160'(32'h0B0B0A0A));

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
